remote_controller: RTL and testbench

REMOTE_CONTROLLER -- requirements
Module: remote_controller

---
 rtl/remote_controller_pkg.sv | 35 +++
 rtl/remote_controller_shift_reg.sv | 35 +++
 rtl/remote_controller.sv | 169 ++++++++++++++++
 tb/tb_remote_controller.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/remote_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : remote_controller_pkg
//  Description : Shared types and constants for the IR remote frame decoder.
//                Optional feature macro: REMOTE_CUSTOM_FILTER_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package remote_controller_pkg;

   localparam int CUSTOM_BITS = 16;
   localparam int KEY_BITS    = 8;

   // custom + key + inverted key, the payload captured by the shift register
   localparam int c_FRAME_BITS = CUSTOM_BITS + 2 * KEY_BITS;
   localparam int c_CNT_W      = 4;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      CUSTOM      = 3'd1,
      KEY         = 3'd2,
      INVKEY      = 3'd3,
      ENDBIT      = 3'd4,
      CHECK       = 3'd5,
      READY_PULSE = 3'd6,
      WAIT_HIGH   = 3'd7
   } state_t;

   // A key byte is trusted only when it arrives with its exact complement
   function automatic logic key_ok(input logic [KEY_BITS-1:0] key,
                                   input logic [KEY_BITS-1:0] inv);
      return (key == ~inv);
   endfunction

endpackage
`default_nettype wire

// File: rtl/remote_controller_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ir_shift_reg
//  Description : Serial-in, parallel-out shift register for IR frame payload.
//                Bits enter at the LSB, so the first bit received ends up MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module ir_shift_reg #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_shift,
   input  logic             i_din,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_data;

   // Shift one bit per enabled cycle; clear on reset or frame start
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data <= '0;
      end else if (i_clr) begin
         r_data <= '0;
      end else if (i_shift) begin
         r_data <= {r_data[WIDTH-2:0], i_din};
      end
   end

   assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/remote_controller.sv
`default_nettype none
// ============================================================================
//  Module      : remote_controller
//  Description : Decodes 34-bit IR remote frames (lead 0, 16 custom bits,
//                8 key bits, 8 inverted key bits, end 1), one bit per clock,
//                and emits the key on Tecla with a PULSE_LEN-cycle Ready.
//                Optional macro REMOTE_CUSTOM_FILTER_EN additionally requires
//                the custom code to equal CUSTOM_CODE.
//  Revision    : 1.0 - initial release
// ============================================================================
module remote_controller
   import remote_controller_pkg::*;
#(
   parameter int          PULSE_LEN   = 2,
   parameter logic [15:0] CUSTOM_CODE = 16'hABCD
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Serial,
   output logic [7:0] Tecla,
   output logic       Ready
);

   state_t               state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [c_CNT_W-1:0]   w_cnt_nxt;
   logic                 r_ready;
   logic                 w_ready_nxt;
   logic [KEY_BITS-1:0]  r_tecla;
   logic [KEY_BITS-1:0]  w_tecla_nxt;
   logic                 w_shift;
   logic                 w_clr;
   logic                 w_accept;
   logic [c_FRAME_BITS-1:0] w_frame;
   logic [CUSTOM_BITS-1:0]  w_custom;
   logic [KEY_BITS-1:0]     w_key;
   logic [KEY_BITS-1:0]     w_inv;

   ir_shift_reg #(
      .WIDTH (c_FRAME_BITS)
   ) u_shift (
      .i_clk   (Clock),
      .i_rst_n (Reset),
      .i_clr   (w_clr),
      .i_shift (w_shift),
      .i_din   (Serial),
      .o_data  (w_frame)
   );

   assign w_custom = w_frame[c_FRAME_BITS-1 -: CUSTOM_BITS];
   assign w_key    = w_frame[2*KEY_BITS-1 -: KEY_BITS];
   assign w_inv    = w_frame[KEY_BITS-1:0];

`ifdef REMOTE_CUSTOM_FILTER_EN
   assign w_accept = key_ok(w_key, w_inv) && (w_custom == CUSTOM_CODE);
`else
   // Custom code is deliberately ignored in this build
   logic w_unused_custom;
   assign w_unused_custom = ^{w_custom, CUSTOM_CODE};
   assign w_accept        = key_ok(w_key, w_inv);
`endif

   // State, bit counter and output registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b0;
         r_tecla <= '0;
      end else begin
         state   <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_ready_nxt;
         r_tecla <= w_tecla_nxt;
      end
   end

   // Next-state, counter and output decode
   always_comb begin
      w_state_nxt = state;
      w_cnt_nxt   = r_cnt;
      w_ready_nxt = r_ready;
      w_tecla_nxt = r_tecla;
      w_shift     = 1'b0;
      w_clr       = 1'b0;
      case (state)
         IDLE: begin
            w_ready_nxt = 1'b0;
            w_tecla_nxt = '0;
            if (!Serial) begin
               w_state_nxt = CUSTOM;
               w_cnt_nxt   = '0;
               w_clr       = 1'b1;
            end
         end
         CUSTOM: begin
            w_shift = 1'b1;
            if (r_cnt == c_CNT_W'(CUSTOM_BITS - 1)) begin
               w_state_nxt = KEY;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         KEY: begin
            w_shift = 1'b1;
            if (r_cnt == c_CNT_W'(KEY_BITS - 1)) begin
               w_state_nxt = INVKEY;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         INVKEY: begin
            w_shift = 1'b1;
            if (r_cnt == c_CNT_W'(KEY_BITS - 1)) begin
               w_state_nxt = ENDBIT;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ENDBIT: begin
            // A missing end bit means a corrupt frame; wait for idle line
            w_state_nxt = Serial ? CHECK : WAIT_HIGH;
         end
         CHECK: begin
            if (w_accept) begin
               w_state_nxt = READY_PULSE;
               w_ready_nxt = 1'b1;
               w_tecla_nxt = w_key;
               w_cnt_nxt   = c_CNT_W'(1);
            end else begin
               w_state_nxt = IDLE;
               w_ready_nxt = 1'b0;
               w_tecla_nxt = '0;
            end
         end
         READY_PULSE: begin
            // r_cnt holds how many cycles Ready has already been high
            if (r_cnt == c_CNT_W'(PULSE_LEN)) begin
               w_state_nxt = IDLE;
               w_ready_nxt = 1'b0;
               w_tecla_nxt = '0;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (Serial) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b0;
            w_tecla_nxt = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign Ready = r_ready;
   assign Tecla = r_tecla;

endmodule
`default_nettype wire

// File: tb/tb_remote_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_remote_controller
//  Description : Directed self-checking bench for remote_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_controller;
   import remote_controller_pkg::*;

   logic       Clock;
   logic       Reset;
   logic       Serial;
   logic [7:0] Tecla;
   logic       Ready;

   int n_checks = 0;
   int n_errors = 0;

`ifdef REMOTE_CUSTOM_FILTER_EN
   localparam logic c_FILT = 1'b1;
`else
   localparam logic c_FILT = 1'b0;
`endif

   remote_controller #(
      .PULSE_LEN   (2),
      .CUSTOM_CODE (16'hABCD)
   ) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Serial (Serial),
      .Tecla  (Tecla),
      .Ready  (Ready)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one bit mid-cycle, let the DUT sample it, then settle
   task automatic send_bit(input logic b);
      @(negedge Clock);
      Serial = b;
      @(posedge Clock);
      #1;
   endtask

   // Send the first n bits of a frame (lead is edge E0, end bit is E33)
   task automatic send_frame(input logic [15:0] c, input logic [7:0] k,
                             input logic [7:0] inv, input logic e, input int n);
      logic [33:0] f;
      f = {1'b0, c, k, inv, e};
      for (int i = 0; i < n; i++) send_bit(f[33-i]);
   endtask

   // Edges E34..E36 with the line idle: pulse present (or not) then IDLE
   task automatic check_pulse(input string tag, input logic [7:0] key, input logic ok);
      send_bit(1'b1);
      chk({tag, "_rdy_e34"}, 32'(Ready), 32'(ok));
      chk({tag, "_key_e34"}, 32'(Tecla), ok ? 32'(key) : 32'h0);
      send_bit(1'b1);
      chk({tag, "_rdy_e35"}, 32'(Ready), 32'(ok));
      chk({tag, "_key_e35"}, 32'(Tecla), ok ? 32'(key) : 32'h0);
      send_bit(1'b1);
      chk({tag, "_rdy_e36"}, 32'(Ready), 32'h0);
      chk({tag, "_key_e36"}, 32'(Tecla), 32'h0);
      chk({tag, "_st_e36"}, 32'(dut.state), 32'(IDLE));
   endtask

   initial begin
      Serial = 1'b1;
      Reset  = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_rdy", 32'(Ready), 32'h0);
      chk("rst_key", 32'(Tecla), 32'h0);
      chk("rst_st", 32'(dut.state), 32'(IDLE));
      @(negedge Clock);
      Reset = 1'b1;

      // Valid frame, no partial output before the check edge
      send_frame(16'hABCD, 8'h01, 8'hFE, 1'b1, 34);
      chk("f1_st_e33", 32'(dut.state), 32'(CHECK));
      chk("f1_rdy_e33", 32'(Ready), 32'h0);
      check_pulse("f1", 8'h01, 1'b1);

      // Back-to-back frame, foreign custom code (rejected only when filtering)
      send_frame(16'h1234, 8'h16, 8'hE9, 1'b1, 34);
      check_pulse("f2", 8'h16, ~c_FILT);

      // Key/inverted-key mismatch
      send_frame(16'hABCD, 8'h01, 8'h01, 1'b1, 34);
      send_bit(1'b1);
      chk("f3_rdy", 32'(Ready), 32'h0);
      chk("f3_key", 32'(Tecla), 32'h0);
      chk("f3_st", 32'(dut.state), 32'(IDLE));

      // Lead bits during CHECK and READY_PULSE must be ignored
      send_frame(16'hABCD, 8'h33, 8'hCC, 1'b1, 34);
      send_bit(1'b0);
      chk("f4_rdy_e34", 32'(Ready), 32'h1);
      chk("f4_key_e34", 32'(Tecla), 32'h33);
      send_bit(1'b0);
      chk("f4_rdy_e35", 32'(Ready), 32'h1);
      send_bit(1'b1);
      chk("f4_rdy_e36", 32'(Ready), 32'h0);
      send_bit(1'b1);
      chk("f4_st_e37", 32'(dut.state), 32'(IDLE));

      // End bit 0: discarded, wait for line high
      send_frame(16'hABCD, 8'h05, 8'hFA, 1'b0, 34);
      chk("f5_st_e33", 32'(dut.state), 32'(WAIT_HIGH));
      for (int i = 0; i < 3; i++) begin
         send_bit(1'b0);
         chk("f5_rdy_low", 32'(Ready), 32'h0);
         chk("f5_st_wait", 32'(dut.state), 32'(WAIT_HIGH));
      end
      send_bit(1'b1);
      chk("f5_st_idle", 32'(dut.state), 32'(IDLE));
      send_frame(16'hABCD, 8'h05, 8'hFA, 1'b1, 34);
      check_pulse("f6", 8'h05, 1'b1);

      // Reset at E20 of a valid frame
      send_frame(16'hABCD, 8'h22, 8'hDD, 1'b1, 20);
      @(negedge Clock);
      Serial = 1'b1;
      Reset  = 1'b0;
      #1;
      chk("f7_st_rst", 32'(dut.state), 32'(IDLE));
      chk("f7_rdy_rst", 32'(Ready), 32'h0);
      chk("f7_key_rst", 32'(Tecla), 32'h0);
      chk("f7_cnt_rst", 32'(dut.r_cnt), 32'h0);
      @(negedge Clock);
      Reset = 1'b1;
      send_frame(16'hABCD, 8'h22, 8'hDD, 1'b1, 34);
      check_pulse("f8", 8'h22, 1'b1);

      // Reset in the middle of a Ready pulse
      send_frame(16'hABCD, 8'h44, 8'hBB, 1'b1, 34);
      send_bit(1'b1);
      chk("f9_rdy_e34", 32'(Ready), 32'h1);
      #2;
      Reset = 1'b0;
      #1;
      chk("f9_rdy_rst", 32'(Ready), 32'h0);
      chk("f9_key_rst", 32'(Tecla), 32'h0);
      chk("f9_st_rst", 32'(dut.state), 32'(IDLE));
      @(negedge Clock);
      Reset = 1'b1;

      // Custom code matching the filter value, any build
      send_frame(16'hABCD, 8'h16, 8'hE9, 1'b1, 34);
      check_pulse("f10", 8'h16, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
